// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-access stage.
// Consumed by mem_stage_if and mem_stage.
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int RF_AW      = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshaked data-memory bus between the memory stage (master) and the data memory (slave).
// A request is held on req/we/addr/wdata until ready; read data returns later with rvalid.
interface mem_stage_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Watchdog for an in-flight memory access: cleared when a request is issued,
// counts every enabled cycle and flags the cycle in which the limit is reached.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expiry is flagged in the cycle whose increment would reach the limit.
    assign o_expired = i_en && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one outstanding data-memory request, stalls upstream while busy,
// drives register-file writeback. Define MEM_TIMEOUT_EN to add the watchdog and o_mem_err.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ex_valid,
    input  logic [DATA_W-1:0] i_ex_dst,
    input  logic [DATA_W-1:0] i_ex_sdata,
    input  logic              i_ex_mem_re,
    input  logic              i_ex_mem_we,
    input  logic              i_ex_rf_we,
    input  logic [RF_AW-1:0]  i_ex_rf_addr,
    output logic              o_stall,
    mem_stage_if.master       dm,
    output logic              o_wb_we,
    output logic [RF_AW-1:0]  o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_busy
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              o_mem_err
`endif
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_mem_op;
    logic              w_issue;
    logic              w_expired;
    logic              r_dm_we;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [DATA_W-1:0] r_dm_wdata;
    logic              r_rf_we;
    logic [RF_AW-1:0]  r_rf_addr;
    logic              r_wb_we;
    logic [RF_AW-1:0]  r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    assign w_mem_op = i_ex_mem_re | i_ex_mem_we;
    assign w_issue  = i_ex_valid & w_mem_op;

`ifdef MEM_TIMEOUT_EN
    logic w_to_hit;
    logic r_mem_err;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  ((r_state == IDLE) && w_issue),
        .i_en     ((r_state == REQ) || (r_state == WAIT)),
        .o_expired(w_expired)
    );

    // A legitimate acceptance or return in the same cycle wins over the timeout.
    assign w_to_hit = w_expired && (((r_state == REQ) && !dm.ready) ||
                                    ((r_state == WAIT) && !dm.rvalid));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_to_hit;
        end
    end

    assign o_mem_err = r_mem_err;
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_issue) w_next_state = REQ;
            REQ: begin
                if (dm.ready) begin
                    w_next_state = r_dm_we ? DONE : WAIT;
                end else if (w_expired) begin
                    w_next_state = DONE;
                end
            end
            WAIT: if (dm.rvalid || w_expired) w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_wb_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_ex_valid && !w_mem_op) begin
                        r_wb_we   <= i_ex_rf_we;
                        r_wb_addr <= i_ex_rf_addr;
                        r_wb_data <= i_ex_dst;
                    end else if (w_issue) begin
                        // A combined load+store is executed as a store and never writes back.
                        r_dm_addr  <= i_ex_dst[ADDR_W-1:0];
                        r_dm_wdata <= i_ex_sdata;
                        r_dm_we    <= i_ex_mem_we;
                        r_rf_we    <= i_ex_rf_we & ~i_ex_mem_we;
                        r_rf_addr  <= i_ex_rf_addr;
                    end
                end
                WAIT: begin
                    if (dm.rvalid) begin
                        r_wb_we   <= r_rf_we;
                        r_wb_addr <= r_rf_addr;
                        r_wb_data <= dm.rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm.req   = (r_state == REQ);
    assign dm.we    = r_dm_we;
    assign dm.addr  = r_dm_addr;
    assign dm.wdata = r_dm_wdata;

    assign o_stall   = w_issue && (r_state != DONE);
    assign o_busy    = (r_state != IDLE);
    assign o_wb_we   = r_wb_we;
    assign o_wb_addr = r_wb_addr;
    assign o_wb_data = r_wb_data;

endmodule
